mac_accum_scheduler: RTL and testbench

Round-robin scheduler that shares one signed multiply-accumulate datapath (20x18 -> 38-bit, add or subtract accumulation) between two requesters. Each requester submits a job as a stream of operand pairs ending with a last flag. The scheduler grants the datapath to one requester per job, clears the accumulator at job start, and applies the job's add/subtract mode. It returns the accumulated result with requester id and beat count over a valid/ready result port. The block sits between the DSP-style MAC datapath and its client engines.

---
 rtl/mac_sched_pkg.sv | 15 +
 rtl/mac_accum_core.sv | 64 ++++++
 rtl/mac_accum_scheduler.sv | 149 ++++++++++++++
 tb/tb_mac_accum_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and default widths for the MAC accumulate scheduler.
package mac_sched_pkg;

  localparam int unsigned A_WIDTH_DEF   = 20;
  localparam int unsigned B_WIDTH_DEF   = 18;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

endpackage

// File: rtl/mac_accum_core.sv
// Two-stage signed multiply-accumulate datapath: input registers, then accumulator.
module mac_accum_core #(
  parameter int unsigned A_WIDTH = 20,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               first,
  input  logic               subtract,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  logic               v_q;
  logic               first_q;
  logic               sub_q;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic [P_WIDTH-1:0] a_ext;
  logic [P_WIDTH-1:0] b_ext;
  logic [P_WIDTH-1:0] prod;
  logic [P_WIDTH-1:0] term;

  // Input stage: capture operands and per-beat control on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= 1'b0;
      first_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      v_q <= en;
      if (en) begin
        first_q <= first;
        sub_q   <= subtract;
        a_q     <= a;
        b_q     <= b;
      end
    end
  end

  // Sign-extend both operands to full width; the truncated product is then
  // the exact signed product modulo 2^P_WIDTH.
  always_comb begin
    a_ext = {{(P_WIDTH - A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
    b_ext = {{(P_WIDTH - B_WIDTH){b_q[B_WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
    term  = sub_q ? (~prod + 1'b1) : prod;
  end

  // Accumulator stage: first beat of a job loads, later beats accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
    end else if (v_q) begin
      p <= first_q ? term : (p + term);
    end
  end

endmodule

// File: rtl/mac_accum_scheduler.sv
// Round-robin scheduler sharing one MAC datapath between two requesters.
module mac_accum_scheduler
  import mac_sched_pkg::*;
#(
  parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH   = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH   = A_WIDTH + B_WIDTH,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_last,
  input  logic                 req0_subtract,
  input  logic [A_WIDTH-1:0]   req0_a,
  input  logic [B_WIDTH-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_last,
  input  logic                 req1_subtract,
  input  logic [A_WIDTH-1:0]   req1_a,
  input  logic [B_WIDTH-1:0]   req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [P_WIDTH-1:0]   res_p,
  output logic [CNT_WIDTH-1:0] res_count
);

  state_t               state;
  state_t               state_next;
  logic                 gnt;
  logic                 prio;
  logic [1:0]           rdy_q;
  logic                 first_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 any_valid;
  logic                 pick;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 sel_sub;
  logic [A_WIDTH-1:0]   sel_a;
  logic [B_WIDTH-1:0]   sel_b;
  logic                 fire;
  logic                 core_sub;
  logic [P_WIDTH-1:0]   core_p;

  // Granted-requester mux, beat handshake and round-robin pick.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    pick      = (req0_valid & req1_valid) ? prio : req1_valid;
    sel_valid = gnt ? req1_valid    : req0_valid;
    sel_last  = gnt ? req1_last     : req0_last;
    sel_sub   = gnt ? req1_subtract : req0_subtract;
    sel_a     = gnt ? req1_a        : req0_a;
    sel_b     = gnt ? req1_b        : req0_b;
    fire      = (|rdy_q) & sel_valid;
    core_sub  = first_q ? sel_sub : mode_q;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_valid)               state_next = STREAM;
      STREAM:  if (fire && sel_last)        state_next = DRAIN;
      DRAIN:                                state_next = RESULT;
      RESULT:  if (res_valid && res_ready)  state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // State, arbiter, registered readies, beat counter and result registers.
  // Readies are registered from the state so the first STREAM cycle has them
  // low, giving a two-edge grant latency and no valid->ready path; RESULT
  // spends its first cycle latching the settled accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      rdy_q     <= '0;
      first_q   <= 1'b0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_p     <= '0;
      res_count <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && any_valid) begin
        gnt     <= pick;
        first_q <= 1'b1;
        cnt     <= '0;
      end

      rdy_q <= '0;
      if (state == STREAM && !(fire && sel_last)) begin
        rdy_q[gnt] <= 1'b1;
      end

      if (fire) begin
        first_q <= 1'b0;
        if (first_q) begin
          mode_q <= sel_sub;
        end
        if (cnt != '1) begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end

      if (state == RESULT && !res_valid) begin
        res_valid <= 1'b1;
        res_id    <= gnt;
        res_p     <= core_p;
        res_count <= cnt;
      end

      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        prio      <= ~gnt;
      end
    end
  end

  assign req0_ready = rdy_q[0];
  assign req1_ready = rdy_q[1];

  mac_accum_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (fire),
    .first    (first_q),
    .subtract (core_sub),
    .a        (sel_a),
    .b        (sel_b),
    .p        (core_p)
  );

endmodule

// File: tb/tb_mac_accum_scheduler.sv
// Directed bench for mac_accum_scheduler: job table plus multi-cycle sequences.
module tb_mac_accum_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_last, req0_subtract;
  logic [19:0] req0_a;
  logic [17:0] req0_b;
  logic        req1_valid, req1_ready, req1_last, req1_subtract;
  logic [19:0] req1_a;
  logic [17:0] req1_b;
  logic        res_valid, res_ready, res_id;
  logic [37:0] res_p;
  logic [7:0]  res_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            id;
    logic            sub;
    logic [2:0]      n;
    logic [3:0][19:0] a;
    logic [3:0][17:0] b;
    logic [3:0]      sub_late;
    logic [3:0]      bubble;
    logic [63:0]     exp_p;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t tbl [5];

  mac_accum_scheduler #(
    .A_WIDTH   (20),
    .B_WIDTH   (18),
    .P_WIDTH   (38),
    .CNT_WIDTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_last     (req0_last),
    .req0_subtract (req0_subtract),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_last     (req1_last),
    .req1_subtract (req1_subtract),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .res_p         (res_p),
    .res_count     (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic last, input logic sub,
                       input logic [19:0] a, input logic [17:0] b);
    if (!id) begin
      req0_valid = v; req0_last = last; req0_subtract = sub; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_last = last; req1_subtract = sub; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Called at a negedge with the beat already driven; returns at the negedge after acceptance.
  task automatic send_beat(input logic id);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (rdy(id)) begin
        @(posedge clk);
        @(negedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  // Called at the first negedge after the last beat was accepted.
  task automatic wait_result(input int exp_lat, input string tag);
    int lat = 1;
    while (!res_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    for (int i = 0; i < int'(v.n); i++) begin
      drive(v.id, 1'b1, (i == int'(v.n) - 1), (i == 0) ? v.sub : v.sub_late[i], v.a[i], v.b[i]);
      send_beat(v.id);
      if (v.bubble[i] && i < int'(v.n) - 1) begin
        drive(v.id, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int j = 0; j < 2; j++) begin
          chk({tag, "_bubble_ready_held"}, 64'(rdy(v.id)), 64'd1);
          @(negedge clk);
        end
      end
    end
    drive(v.id, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_result(3, tag);
    chk({tag, "_res_p"},     {26'b0, res_p},     {26'b0, v.exp_p[37:0]});
    chk({tag, "_res_id"},    64'(res_id),        64'(v.id));
    chk({tag, "_res_count"}, 64'(res_count),     64'(v.exp_cnt));
    handshake(tag);
  endtask

  task automatic serve_one(input logic exp_id, input logic [37:0] exp_p, input string tag);
    int k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_res_id"},    64'(res_id),    64'(exp_id));
    chk({tag, "_res_p"},     {26'b0, res_p}, {26'b0, exp_p});
    handshake(tag);
  endtask

  function automatic void setb(input int k, input int i, input int a, input int b);
    tbl[k].a[i] = 20'(a);
    tbl[k].b[i] = 18'(b);
  endfunction

  initial begin
    // Job table: operands, mode, per-beat late subtract, bubbles, expected result.
    for (int k = 0; k < 5; k++) tbl[k] = '0;
    tbl[0].id = 1'b0; tbl[0].sub = 1'b0; tbl[0].n = 3'd1;
    setb(0, 0, 5, 2);
    tbl[0].exp_p = 64'sd10; tbl[0].exp_cnt = 8'd1;

    tbl[1].id = 1'b1; tbl[1].sub = 1'b1; tbl[1].n = 3'd3; tbl[1].sub_late = 4'b1111;
    tbl[1].bubble = 4'b0001;
    setb(1, 0, 5, 2); setb(1, 1, 3, -4); setb(1, 2, -7, 6);
    tbl[1].exp_p = 64'sd44; tbl[1].exp_cnt = 8'd3;

    tbl[2].id = 1'b0; tbl[2].sub = 1'b0; tbl[2].n = 3'd2;
    setb(2, 0, -524288, -131072); setb(2, 1, -524288, -131072);
    tbl[2].exp_p = -64'sd137438953472; tbl[2].exp_cnt = 8'd2;

    tbl[3].id = 1'b0; tbl[3].sub = 1'b1; tbl[3].n = 3'd2; tbl[3].sub_late = 4'b0000;
    setb(3, 0, 100, 100); setb(3, 1, 1, 1);
    tbl[3].exp_p = -64'sd10001; tbl[3].exp_cnt = 8'd2;

    tbl[4].id = 1'b1; tbl[4].sub = 1'b0; tbl[4].n = 3'd2; tbl[4].sub_late = 4'b1111;
    setb(4, 0, 524287, 131071); setb(4, 1, -1, 1);
    tbl[4].exp_p = 64'sd68718821376; tbl[4].exp_cnt = 8'd2;

    // Reset held two cycles with req0 requesting.
    reset = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_res_valid",  64'(res_valid),  64'd0);
    chk("rst_res_p",      {26'b0, res_p},  64'd0);
    chk("rst_res_id",     64'(res_id),     64'd0);
    chk("rst_res_count",  64'(res_count),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("grant_lat_edge1", 64'(req0_ready), 64'd0);
    @(negedge clk);
    chk("grant_lat_edge2", 64'(req0_ready), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    for (int k = 0; k < 5; k++) run_vec(tbl[k], k);

    // Arbitration: both requesters continuously valid with single-beat jobs.
    pulse_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 20'd1, 18'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 20'd2, 18'd3);
    serve_one(1'b0, 38'd1, "arb_first");
    chk("turn_r0_ready1", 64'(req1_ready), 64'd0);
    chk("turn_r0_ready0", 64'(req0_ready), 64'd0);
    @(negedge clk);
    chk("turn_r1_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    chk("turn_r2_ready1", 64'(req1_ready), 64'd1);
    chk("turn_r2_ready0", 64'(req0_ready), 64'd0);
    serve_one(1'b1, 38'd6, "arb_second");
    serve_one(1'b0, 38'd1, "arb_third");
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    // Backpressure in RESULT, then reset while the result is pending.
    pulse_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 20'd3, 18'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 20'd7, 18'd7);
    begin
      int k = 0;
      while (!res_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid",  64'(res_valid),  64'd1);
      chk("bp_res_p",      {26'b0, res_p},  64'd12);
      chk("bp_res_id",     64'(res_id),     64'd0);
      chk("bp_req0_ready", 64'(req0_ready), 64'd0);
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
      @(negedge clk);
    end
    pulse_reset();
    chk("rres_res_valid", 64'(res_valid),  64'd0);
    chk("rres_res_p",     {26'b0, res_p},  64'd0);
    chk("rres_res_id",    64'(res_id),     64'd0);
    chk("rres_res_count", 64'(res_count),  64'd0);
    chk("rres_req0_rdy",  64'(req0_ready), 64'd0);
    @(negedge clk);
    chk("rres_idle_grant", 64'(req0_ready), 64'd0);
    @(negedge clk);
    chk("rres_req0_wins", 64'(req0_ready), 64'd1);
    chk("rres_req1_low",  64'(req1_ready), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    // Beat counter saturation: 260 beats of 1*1.
    pulse_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 1'b1, (i == 259), 1'b0, 20'd1, 18'd1);
      send_beat(1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_result(3, "sat");
    chk("sat_res_p",     {26'b0, res_p},  64'd260);
    chk("sat_res_count", 64'(res_count),  64'd255);
    handshake("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
